// File: rtl/dual_port_memory.sv
// Dual-port byte-maskable RAM (port A read/write, port B read-only) on the falling clock edge,
// self-clearing after reset. Define MEMORY_OUTREG_EN to add a second output register per port.
module dual_port_memory #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16,
    parameter int ByteWidth = 8,
    localparam int Lanes    = DataWidth / ByteWidth
) (
    input  logic                 Clk,
    input  logic                 Reset,
    output logic                 Ready,
    input  logic                 A_Mem_En,
    input  logic                 A_Write_EN,
    input  logic [Lanes-1:0]     A_Byte_En,
    input  logic [AddrWidth-1:0] A_Address,
    input  logic [DataWidth-1:0] A_DIn,
    output logic [DataWidth-1:0] A_DOut,
    output logic                 A_Valid,
    input  logic                 B_Mem_En,
    input  logic [AddrWidth-1:0] B_Address,
    output logic [DataWidth-1:0] B_DOut,
    output logic                 B_Valid
);

    localparam int Depth = 1 << AddrWidth;
    localparam logic [AddrWidth-1:0] CntOne  = {{(AddrWidth-1){1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] CntLast = {AddrWidth{1'b1}};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic [DataWidth-1:0] merge_lanes(
        input logic [DataWidth-1:0] old_word,
        input logic [DataWidth-1:0] new_word,
        input logic [Lanes-1:0]     mask
    );
        logic [DataWidth-1:0] res;
        res = old_word;
        for (int i = 0; i < Lanes; i++) begin
            if (mask[i]) begin
                res[i*ByteWidth +: ByteWidth] = new_word[i*ByteWidth +: ByteWidth];
            end
        end
        return res;
    endfunction

    logic [DataWidth-1:0] mem [Depth];

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d;

    logic                 mem_we;
    logic [AddrWidth-1:0] mem_waddr;
    logic [DataWidth-1:0] mem_wdata;
    logic [Lanes-1:0]     mem_wmask;
    logic                 a_rd, b_rd;

    logic [DataWidth-1:0] a_data_p1_q, a_data_p1_d;
    logic [DataWidth-1:0] b_data_p1_q, b_data_p1_d;
    logic                 a_vld_p1_q, a_vld_p1_d;
    logic                 b_vld_p1_q, b_vld_p1_d;

    // Control: the clear sweep owns the write port until the last address is zeroed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wmask = '0;
        a_rd      = 1'b0;
        b_rd      = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                mem_wmask = '1;
                cnt_d     = cnt_q + CntOne;
                if (cnt_q == CntLast) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                a_rd = ~A_Mem_En & A_Write_EN;
                b_rd = ~B_Mem_En;
                if (~A_Mem_En & ~A_Write_EN) begin
                    mem_we    = 1'b1;
                    mem_waddr = A_Address;
                    mem_wdata = A_DIn;
                    mem_wmask = A_Byte_En;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Stage p1: array read is combinational before the edge, so a same-edge write is not seen.
    always_comb begin
        a_data_p1_d = a_rd ? mem[A_Address] : a_data_p1_q;
        b_data_p1_d = b_rd ? mem[B_Address] : b_data_p1_q;
        a_vld_p1_d  = a_rd;
        b_vld_p1_d  = b_rd;
    end

    always_ff @(negedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= merge_lanes(mem[mem_waddr], mem_wdata, mem_wmask);
        end
    end

    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            a_data_p1_q <= '0;
            b_data_p1_q <= '0;
            a_vld_p1_q  <= 1'b0;
            b_vld_p1_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_data_p1_q <= a_data_p1_d;
            b_data_p1_q <= b_data_p1_d;
            a_vld_p1_q  <= a_vld_p1_d;
            b_vld_p1_q  <= b_vld_p1_d;
        end
    end

`ifdef MEMORY_OUTREG_EN
    logic [DataWidth-1:0] a_data_p2_q, a_data_p2_d;
    logic [DataWidth-1:0] b_data_p2_q, b_data_p2_d;
    logic                 a_vld_p2_q, a_vld_p2_d;
    logic                 b_vld_p2_q, b_vld_p2_d;

    // Stage p2: forwards only real results so DOut still holds between reads.
    always_comb begin
        a_data_p2_d = a_vld_p1_q ? a_data_p1_q : a_data_p2_q;
        b_data_p2_d = b_vld_p1_q ? b_data_p1_q : b_data_p2_q;
        a_vld_p2_d  = a_vld_p1_q;
        b_vld_p2_d  = b_vld_p1_q;
    end

    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            a_data_p2_q <= '0;
            b_data_p2_q <= '0;
            a_vld_p2_q  <= 1'b0;
            b_vld_p2_q  <= 1'b0;
        end else begin
            a_data_p2_q <= a_data_p2_d;
            b_data_p2_q <= b_data_p2_d;
            a_vld_p2_q  <= a_vld_p2_d;
            b_vld_p2_q  <= b_vld_p2_d;
        end
    end

    assign A_DOut  = a_data_p2_q;
    assign B_DOut  = b_data_p2_q;
    assign A_Valid = a_vld_p2_q;
    assign B_Valid = b_vld_p2_q;
`else
    assign A_DOut  = a_data_p1_q;
    assign B_DOut  = b_data_p1_q;
    assign A_Valid = a_vld_p1_q;
    assign B_Valid = b_vld_p1_q;
`endif

    assign Ready = (state_q == RUN);

endmodule

// File: tb/tb_dual_port_memory.sv
// Directed bench for dual_port_memory with AddrWidth=4: clear sequence, byte masks,
// read-first collision, pipelined reads and reset during a read burst.
module tb_dual_port_memory;

`ifdef MEMORY_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        Clk;
    logic        Reset;
    logic        Ready;
    logic        A_Mem_En;
    logic        A_Write_EN;
    logic [1:0]  A_Byte_En;
    logic [3:0]  A_Address;
    logic [15:0] A_DIn;
    logic [15:0] A_DOut;
    logic        A_Valid;
    logic        B_Mem_En;
    logic [3:0]  B_Address;
    logic [15:0] B_DOut;
    logic        B_Valid;

    int n_tests;
    int n_fail;

    dual_port_memory #(
        .AddrWidth(4),
        .DataWidth(16),
        .ByteWidth(8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Ready     (Ready),
        .A_Mem_En  (A_Mem_En),
        .A_Write_EN(A_Write_EN),
        .A_Byte_En (A_Byte_En),
        .A_Address (A_Address),
        .A_DIn     (A_DIn),
        .A_DOut    (A_DOut),
        .A_Valid   (A_Valid),
        .B_Mem_En  (B_Mem_En),
        .B_Address (B_Address),
        .B_DOut    (B_DOut),
        .B_Valid   (B_Valid)
    );

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          a_req;
        bit          a_wr;
        logic [3:0]  a_addr;
        logic [1:0]  be;
        logic [15:0] din;
        bit          b_req;
        logic [3:0]  b_addr;
        bit          exp_av;
        logic [15:0] exp_ad;
        bit          exp_bv;
        logic [15:0] exp_bd;
    } vec_t;

    vec_t vt [13];

    logic [3:0]  pa_addr [3];
    logic [3:0]  pb_addr [3];
    logic [15:0] pa_exp  [3];
    logic [15:0] pb_exp  [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        A_Mem_En   = 1'b1;
        A_Write_EN = 1'b1;
        B_Mem_En   = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        A_Mem_En   = ~v.a_req;
        A_Write_EN = ~v.a_wr;
        A_Address  = v.a_addr;
        A_Byte_En  = v.be;
        A_DIn      = v.din;
        B_Mem_En   = ~v.b_req;
        B_Address  = v.b_addr;
        @(negedge Clk); #1;
        idle();
        for (int k = 1; k < LAT; k++) begin
            @(negedge Clk); #1;
        end
        chk({tag, " A_Valid"}, A_Valid, v.exp_av);
        chk({tag, " A_DOut"},  A_DOut,  v.exp_ad);
        chk({tag, " B_Valid"}, B_Valid, v.exp_bv);
        chk({tag, " B_DOut"},  B_DOut,  v.exp_bd);
    endtask

    // Counts falling edges until Ready, optionally hammering both ports meanwhile.
    task automatic wait_clear(input bit drive, input string tag);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done && n < 40) begin
            if (drive) begin
                A_Mem_En   = 1'b0;
                A_Write_EN = n[0];
                A_Address  = 4'h3;
                A_Byte_En  = 2'b11;
                A_DIn      = 16'hBEEF;
                B_Mem_En   = 1'b0;
                B_Address  = n[3:0];
            end
            @(negedge Clk); #1;
            n++;
            chk({tag, " A_Valid in clear"}, A_Valid, 1'b0);
            chk({tag, " B_Valid in clear"}, B_Valid, 1'b0);
            if (Ready) done = 1;
        end
        idle();
        chk({tag, " clear edge count"}, n, 16);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        A_Mem_En   = 1'b1;
        A_Write_EN = 1'b1;
        A_Byte_En  = 2'b00;
        A_Address  = 4'h0;
        A_DIn      = 16'h0000;
        B_Mem_En   = 1'b1;
        B_Address  = 4'h0;

        //          a_req a_wr addr  be     din       b_req baddr av ad         bv bd
        vt[0]  = '{1'b1, 1'b1, 4'h3, 2'b11, 16'hBEEF, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 1'b0, 4'h3, 2'b00, 16'h0000, 1'b0, 4'h0, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
        vt[2]  = '{1'b1, 1'b1, 4'h3, 2'b01, 16'h1234, 1'b0, 4'h0, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        vt[3]  = '{1'b1, 1'b0, 4'h3, 2'b00, 16'h0000, 1'b0, 4'h0, 1'b1, 16'hBE34, 1'b0, 16'h0000};
        vt[4]  = '{1'b1, 1'b1, 4'h3, 2'b00, 16'hFFFF, 1'b0, 4'h0, 1'b0, 16'hBE34, 1'b0, 16'h0000};
        vt[5]  = '{1'b1, 1'b0, 4'h3, 2'b00, 16'h0000, 1'b1, 4'h3, 1'b1, 16'hBE34, 1'b1, 16'hBE34};
        vt[6]  = '{1'b1, 1'b1, 4'h5, 2'b11, 16'h1111, 1'b0, 4'h0, 1'b0, 16'hBE34, 1'b0, 16'hBE34};
        vt[7]  = '{1'b1, 1'b1, 4'h5, 2'b11, 16'h2222, 1'b1, 4'h5, 1'b0, 16'hBE34, 1'b1, 16'h1111};
        vt[8]  = '{1'b0, 1'b0, 4'h0, 2'b00, 16'h0000, 1'b1, 4'h5, 1'b0, 16'hBE34, 1'b1, 16'h2222};
        vt[9]  = '{1'b1, 1'b1, 4'h5, 2'b10, 16'hCDEF, 1'b0, 4'h0, 1'b0, 16'hBE34, 1'b0, 16'h2222};
        vt[10] = '{1'b1, 1'b0, 4'h5, 2'b00, 16'h0000, 1'b1, 4'h3, 1'b1, 16'hCD22, 1'b1, 16'hBE34};
        vt[11] = '{1'b1, 1'b0, 4'hF, 2'b00, 16'h0000, 1'b1, 4'h0, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vt[12] = '{1'b0, 1'b0, 4'h0, 2'b00, 16'h0000, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000};

        pa_addr[0] = 4'h3; pa_exp[0] = 16'hBE34;
        pa_addr[1] = 4'h5; pa_exp[1] = 16'hCD22;
        pa_addr[2] = 4'hF; pa_exp[2] = 16'h0000;
        pb_addr[0] = 4'h5; pb_exp[0] = 16'hCD22;
        pb_addr[1] = 4'h3; pb_exp[1] = 16'hBE34;
        pb_addr[2] = 4'h0; pb_exp[2] = 16'h0000;

        #22;
        chk("reset Ready",   Ready,   1'b0);
        chk("reset A_DOut",  A_DOut,  16'h0000);
        chk("reset B_DOut",  B_DOut,  16'h0000);
        chk("reset A_Valid", A_Valid, 1'b0);
        chk("reset B_Valid", B_Valid, 1'b0);
        #1 Reset = 1'b0;

        // Initial clear with requests active the whole time; they must be ignored.
        wait_clear(1'b1, "clear1");

        for (int i = 0; i < 16; i++) begin
            vec_t rv;
            rv = '{1'b1, 1'b0, i[3:0], 2'b00, 16'h0000, 1'b1, 4'(15 - i),
                   1'b1, 16'h0000, 1'b1, 16'h0000};
            apply_vec(rv, $sformatf("zero rd %0d", i));
        end

        for (int i = 0; i < 13; i++) begin
            apply_vec(vt[i], $sformatf("vec %0d", i));
        end

        // Back-to-back reads on both ports, one result per cycle.
        for (int k = 0; k < 3 + LAT; k++) begin
            int j;
            if (k < 3) begin
                A_Mem_En   = 1'b0;
                A_Write_EN = 1'b1;
                A_Address  = pa_addr[k];
                B_Mem_En   = 1'b0;
                B_Address  = pb_addr[k];
            end else begin
                idle();
            end
            @(negedge Clk); #1;
            j = k - (LAT - 1);
            if (j >= 0 && j < 3) begin
                chk($sformatf("pipe %0d A_Valid", j), A_Valid, 1'b1);
                chk($sformatf("pipe %0d A_DOut", j),  A_DOut,  pa_exp[j]);
                chk($sformatf("pipe %0d B_Valid", j), B_Valid, 1'b1);
                chk($sformatf("pipe %0d B_DOut", j),  B_DOut,  pb_exp[j]);
            end else if (j == 3) begin
                chk("pipe end A_Valid", A_Valid, 1'b0);
                chk("pipe end A_DOut",  A_DOut,  16'h0000);
                chk("pipe end B_Valid", B_Valid, 1'b0);
                chk("pipe end B_DOut",  B_DOut,  16'h0000);
            end
        end

        apply_vec('{1'b1, 1'b1, 4'h3, 2'b11, 16'hBEEF, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 16'h0000},
                  "pre-reset wr");
        apply_vec('{1'b1, 1'b0, 4'h3, 2'b00, 16'h0000, 1'b1, 4'h3, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF},
                  "pre-reset rd");

        // Read burst interrupted by an asynchronous reset between clock edges.
        A_Mem_En   = 1'b0;
        A_Write_EN = 1'b1;
        A_Address  = 4'h3;
        B_Mem_En   = 1'b0;
        B_Address  = 4'h3;
        repeat (2) begin
            @(negedge Clk); #1;
        end
        #3 Reset = 1'b1;
        #1;
        chk("async rst Ready",   Ready,   1'b0);
        chk("async rst A_DOut",  A_DOut,  16'h0000);
        chk("async rst B_DOut",  B_DOut,  16'h0000);
        chk("async rst A_Valid", A_Valid, 1'b0);
        chk("async rst B_Valid", B_Valid, 1'b0);
        idle();
        #10 Reset = 1'b0;

        wait_clear(1'b0, "clear2");
        apply_vec('{1'b1, 1'b0, 4'h3, 2'b00, 16'h0000, 1'b1, 4'h3, 1'b1, 16'h0000, 1'b1, 16'h0000},
                  "post-reset rd");
        apply_vec('{1'b1, 1'b0, 4'h5, 2'b00, 16'h0000, 1'b1, 4'h0, 1'b1, 16'h0000, 1'b1, 16'h0000},
                  "post-reset rd2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_memory.md
DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 SHALL have parameter AddrWidth, default 8, address bits; depth = 2^AddrWidth words.
REQ-002 SHALL have parameter DataWidth, default 16, word width in bits.
REQ-003 SHALL have parameter ByteWidth, default 8, lane width; DataWidth must be an integer multiple of ByteWidth; Lanes = DataWidth/ByteWidth.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, both listed first: Clk  in  1  clock, all sampling on the falling edge; Reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have Ready  out  1  high when the clear sequence is done and the ports accept requests.
REQ-006 SHALL have A_Mem_En  in  1  port A enable, active low.
REQ-007 SHALL have A_Write_EN  in  1  port A write enable, active low; high = read.
REQ-008 SHALL have A_Byte_En  in  Lanes  per-lane write mask, active high.
REQ-009 SHALL have A_Address  in  AddrWidth  port A address.
REQ-010 SHALL have A_DIn  in  DataWidth  port A write data.
REQ-011 SHALL have A_DOut  out  DataWidth  port A registered read data.
REQ-012 SHALL have A_Valid  out  1  one-cycle pulse marking new A_DOut.
REQ-013 SHALL have B_Mem_En  in  1  port B read enable, active low; port B is read-only.
REQ-014 SHALL have B_Address  in  AddrWidth  port B address.
REQ-015 SHALL have B_DOut  out  DataWidth  port B registered read data.
REQ-016 SHALL have B_Valid  out  1  one-cycle pulse marking new B_DOut.

Function
REQ-017 SHALL implement a two-state FSM, CLEAR and RUN; Reset forces CLEAR with clear counter = 0.
REQ-018 In CLEAR, SHALL write zero to mem[counter] on each falling edge and then increment the counter; after writing address 2^AddrWidth-1, SHALL go to RUN; clear takes exactly 2^AddrWidth edges.
REQ-019 Ready SHALL be 0 in CLEAR and 1 in RUN; all port requests SHALL be ignored in CLEAR: no write, no Valid.
REQ-020 In RUN, a port A read (~A_Mem_En & A_Write_EN) SHALL register mem[A_Address] into A_DOut and pulse A_Valid.
REQ-021 In RUN, a port A write (~A_Mem_En & ~A_Write_EN) SHALL update only lanes with A_Byte_En[i]=1; A_Byte_En=0 SHALL leave the word unchanged; a write SHALL NOT change A_DOut or pulse A_Valid.
REQ-022 In RUN, ~B_Mem_En SHALL register mem[B_Address] into B_DOut and pulse B_Valid.
REQ-023 Port A write and port B read to the same address on the same edge SHALL give read-first behaviour: B_DOut returns the pre-write word.
REQ-024 Back-to-back reads SHALL be fully pipelined, one result per port per cycle.
REQ-025 When no read is issued, DOut SHALL hold its last value and Valid SHALL be 0.
REQ-026 Ports A and B SHALL operate independently on the same edge, including both reading the same address.

Reset
REQ-027 Reset SHALL asynchronously force A_DOut=0, B_DOut=0, A_Valid=0, B_Valid=0, Ready=0, state=CLEAR, counter=0, and clear any pipeline stages.
REQ-028 Reset asserted mid-CLEAR or mid-RUN SHALL restart the clear from address 0; in-flight reads SHALL be discarded with no Valid pulse.

Configuration
REQ-029 Macro MEMORY_OUTREG_EN defined: SHALL add a second output register per port; read latency = 2 falling edges, with Valid delayed to align with the data.
REQ-030 MEMORY_OUTREG_EN undefined: read latency SHALL be 1 falling edge (DOut/Valid update on the edge that samples the request); all other behaviour is identical.

Verification
REQ-031 Reset pulse with AddrWidth=4 -> Ready=0 for 16 falling edges, then 1; reading all 16 addresses returns 0x0000.
REQ-032 A write 0xBEEF @0x03 with Byte_En=2'b11, then A read @0x03 -> A_DOut=0xBEEF with A_Valid pulse after 1 edge (2 edges with MEMORY_OUTREG_EN).
REQ-033 Word 0xBEEF, then A write 0x1234 with Byte_En=2'b01 -> read returns 0xBE34; write with Byte_En=2'b00 -> still 0xBE34.
REQ-034 Word @0x05=0x1111; same edge A writes 0x2222 @0x05 and B reads @0x05 -> B_DOut=0x1111; next B read -> 0x2222.
REQ-035 Reset asserted during a read burst in RUN -> DOut/Valid go 0 immediately with no clock, Ready=0, clear restarts, and a prior 0xBEEF @0x03 reads 0x0000 after Ready.
REQ-036 Requests issued while Ready=0 -> no Valid pulses, and memory holds zero after clear completes.
